// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//
// Push-button driven display-mode controller for the Alhambra II LED bank.
// Every debounced press of SW1 advances the display mode:
//    OFF -> BLINK -> CHASE -> BREATHE -> OFF          (LED_BREATHE_EN defined)
//    OFF -> BLINK -> CHASE -> OFF                     (LED_BREATHE_EN undefined)
//
// Build option:
//    LED_BREATHE_EN  compiles in the BREATHE mode, its 8-bit PWM and the
//                    triangle duty generator. Left undefined, that logic is
//                    absent and the mode FSM has three states.
//
// Parameters:
//    DEBOUNCE_CYC  consecutive changed-input cycles needed to accept a level
//    STEP_CYC      cycles per blink/chase step
//    BREATHE_CYC   cycles per +/-1 change of the breathe duty
//
// Ports:
//    CLK         in   12 MHz board clock
//    RST         in   synchronous active-high reset
//    SW1         in   push-button, 1 = pressed, asynchronous to CLK
//    LED7..LED0  out  LED drive, 1 = lit, registered
// -----------------------------------------------------------------------------
module led_mode_ctrl #(
   parameter int DEBOUNCE_CYC = 240000,
   parameter int STEP_CYC     = 1500000,
   parameter int BREATHE_CYC  = 23437
) (
   input  logic CLK,
   input  logic RST,
   input  logic SW1,
   output logic LED7,
   output logic LED6,
   output logic LED5,
   output logic LED4,
   output logic LED3,
   output logic LED2,
   output logic LED1,
   output logic LED0
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_CHASE   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int STEP_W = $clog2(STEP_CYC + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

   // ---------------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous button
   // ---------------------------------------------------------------------------
   logic s1;
   logic s2;

   // NOTE: registers are written with <= so every flop samples the values from
   // before the edge; blocking = here would collapse s1/s2 into a single stage.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= SW1;
         s2 <= s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Debouncer: the accepted level flips only after s2 has disagreed with it
   // for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
   // ---------------------------------------------------------------------------
   logic            stable;
   logic            stable_d;
   logic [DB_W-1:0] db_cnt;
   logic            press;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stable   <= 1'b0;
         stable_d <= 1'b0;
         db_cnt   <= '0;
      end else begin
         stable_d <= stable;
         if (s2 != stable) begin
            if (db_cnt == DB_LAST) begin
               stable <= ~stable;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // Rising edge of the accepted level only; release produces no event.
   assign press = stable & ~stable_d;

   // ---------------------------------------------------------------------------
   // Mode FSM
   // ---------------------------------------------------------------------------
   mode_t mode;
   mode_t mode_nxt;

   always_ff @(posedge CLK) begin
      if (RST) mode <= MODE_OFF;
      else     mode <= mode_nxt;
   end

   // NOTE: mode_nxt gets its hold value before the case so that every path
   // assigns it; a missing branch would otherwise infer a latch.
   always_comb begin
      mode_nxt = mode;
      if (press) begin
         case (mode)
            MODE_OFF:     mode_nxt = MODE_BLINK;
            MODE_BLINK:   mode_nxt = MODE_CHASE;
`ifdef LED_BREATHE_EN
            MODE_CHASE:   mode_nxt = MODE_BREATHE;
            MODE_BREATHE: mode_nxt = MODE_OFF;
`else
            MODE_CHASE:   mode_nxt = MODE_OFF;
`endif
            default:      mode_nxt = MODE_OFF;
         endcase
      end
   end

   // Every press changes the mode, so the press pulse doubles as the
   // mode-entry restart for all the per-mode state below.
   logic mode_chg;
   assign mode_chg = press;

   // ---------------------------------------------------------------------------
   // Step prescaler, blink phase and chase position
   // ---------------------------------------------------------------------------
   logic              step_run;
   logic              step_tick;
   logic [STEP_W-1:0] step_cnt;
   logic              phase;
   logic [2:0]        pos;

   assign step_run  = (mode == MODE_BLINK) || (mode == MODE_CHASE);
   assign step_tick = step_run && (step_cnt == STEP_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         step_cnt <= '0;
         phase    <= 1'b1;
         pos      <= 3'd0;
      end else if (mode_chg) begin
         // A mode change on the same cycle as a tick discards the tick.
         step_cnt <= '0;
         phase    <= 1'b1;
         pos      <= 3'd0;
      end else if (step_run) begin
         if (step_tick) begin
            step_cnt <= '0;
            if (mode == MODE_BLINK) phase <= ~phase;
            else                    pos   <= pos + 3'd1;
         end else begin
            step_cnt <= step_cnt + STEP_W'(1);
         end
      end
   end

`ifdef LED_BREATHE_EN
   // ---------------------------------------------------------------------------
   // Breathe: free-running 8-bit PWM against a triangle-swept duty. The duty
   // turns around at 255 and 0 so each endpoint lasts exactly one step.
   // ---------------------------------------------------------------------------
   localparam int BR_W = $clog2(BREATHE_CYC + 1);
   localparam logic [BR_W-1:0] BR_LAST = BR_W'(BREATHE_CYC - 1);

   logic [7:0]      pwm_cnt;
   logic [BR_W-1:0] br_cnt;
   logic [7:0]      duty;
   logic            dir_up;
   logic            br_run;
   logic            br_tick;
   logic            breathe_lit;

   assign br_run      = (mode == MODE_BREATHE);
   assign br_tick     = br_run && (br_cnt == BR_LAST);
   assign breathe_lit = (pwm_cnt < duty);

   always_ff @(posedge CLK) begin
      if (RST) pwm_cnt <= 8'd0;
      else     pwm_cnt <= pwm_cnt + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         br_cnt <= '0;
         duty   <= 8'd0;
         dir_up <= 1'b1;
      end else if (mode_chg) begin
         br_cnt <= '0;
         duty   <= 8'd0;
         dir_up <= 1'b1;
      end else if (br_run) begin
         if (br_tick) begin
            br_cnt <= '0;
            if (dir_up && duty == 8'd255) begin
               dir_up <= 1'b0;
               duty   <= 8'd254;
            end else if (!dir_up && duty == 8'd0) begin
               dir_up <= 1'b1;
               duty   <= 8'd1;
            end else if (dir_up) begin
               duty <= duty + 8'd1;
            end else begin
               duty <= duty - 8'd1;
            end
         end else begin
            br_cnt <= br_cnt + BR_W'(1);
         end
      end
   end
`else
   // Breathe timing has no consumer in this build.
   logic unused_breathe_cyc;
   assign unused_breathe_cyc = (BREATHE_CYC > 0);
`endif

   // ---------------------------------------------------------------------------
   // LED output register
   // ---------------------------------------------------------------------------
   logic [7:0] led_nxt;
   logic [7:0] led_q;

   always_comb begin
      led_nxt = 8'd0;
      case (mode)
         MODE_BLINK:   led_nxt[7] = phase;
         MODE_CHASE:   led_nxt    = 8'd1 << pos;
`ifdef LED_BREATHE_EN
         MODE_BREATHE: led_nxt    = {8{breathe_lit}};
`endif
         default:      led_nxt    = 8'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) led_q <= 8'd0;
      else     led_q <= led_nxt;
   end

   assign LED7 = led_q[7];
   assign LED6 = led_q[6];
   assign LED5 = led_q[5];
   assign LED4 = led_q[4];
   assign LED3 = led_q[3];
   assign LED2 = led_q[2];
   assign LED1 = led_q[1];
   assign LED0 = led_q[0];

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
//
// Drives SW1/RST with directed and randomized patterns and compares the LED
// bank every cycle against a timeline model: the model tracks which mode is
// active and since which edge, and derives the expected LEDs from elapsed time
// (steps = elapsed / STEP_CYC, duty = triangle(elapsed / BREATHE_CYC)).
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;

   localparam int D = 4;   // DEBOUNCE_CYC
   localparam int S = 8;   // STEP_CYC
   localparam int B = 1;   // BREATHE_CYC
`ifdef LED_BREATHE_EN
   localparam int NM = 4;
`else
   localparam int NM = 3;
`endif

   logic CLK = 1'b0;
   logic RST;
   logic SW1;
   logic LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0;
   logic [7:0] leds;

   led_mode_ctrl #(
      .DEBOUNCE_CYC (D),
      .STEP_CYC     (S),
      .BREATHE_CYC  (B)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .SW1  (SW1),
      .LED7 (LED7),
      .LED6 (LED6),
      .LED5 (LED5),
      .LED4 (LED4),
      .LED3 (LED3),
      .LED2 (LED2),
      .LED1 (LED1),
      .LED0 (LED0)
   );

   always #5 CLK = ~CLK;

   assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int         g       = 0;   // edge index
   int         m_mode  = 0;   // 0 off, 1 blink, 2 chase, 3 breathe
   int         m_entry = 0;   // edge at which the current mode began
   int         m_rst   = 0;   // last reset edge
   bit         m_stable;
   bit         m_press;
   bit         rst_h  [64];
   bit         sw_h   [64];
   bit         seen_h [64];   // button level as seen by the debouncer at an edge
   logic [7:0] exp_led = 8'd0;

   function automatic int tri_duty(input int k);
      int m;
      m = k % 510;
      return (m <= 255) ? m : 510 - m;
   endfunction

   function automatic logic [7:0] mode_leds(input int mode, input int j, input int pwm);
      case (mode)
         1:       return ((j / S) % 2 == 0) ? 8'h80 : 8'h00;
         2:       return 8'(1 << ((j / S) % 8));
         3:       return (pwm < tri_duty(j / B)) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_edge(input bit rst, input bit sw);
      bit flip;
      g++;
      rst_h[g % 64] = rst;
      sw_h[g % 64]  = sw;
      // Button reaches the debouncer two edges after sampling, zeroed by reset.
      seen_h[g % 64] = (g > 2 && !rst_h[(g - 1) % 64] && !rst_h[(g - 2) % 64])
                       ? sw_h[(g - 2) % 64] : 1'b0;
      if (rst) begin
         m_stable = 1'b0;
         m_press  = 1'b0;
         m_mode   = 0;
         m_entry  = g;
         m_rst    = g;
         exp_led  = 8'h00;
      end else begin
         exp_led = mode_leds(m_mode, g - 1 - m_entry, (g - 1 - m_rst) % 256);
         if (m_press) begin
            m_mode  = (m_mode + 1) % NM;
            m_entry = g;
            m_press = 1'b0;
         end
         // Accept a new level once the last D seen samples all disagree.
         flip = (g > D);
         for (int k = 0; k < D; k++)
            if (seen_h[(g - k) % 64] == m_stable) flip = 1'b0;
         if (flip) begin
            m_stable = ~m_stable;
            if (m_stable) m_press = 1'b1;
         end
      end
   endtask

   // One clock: drive, clock, update model, sample at the falling edge.
   task automatic tick(input bit rst, input bit sw);
      RST = rst;
      SW1 = sw;
      @(posedge CLK);
      model_edge(rst, sw);
      @(negedge CLK);
      check("led", leds, exp_led);
   endtask

   task automatic press_release(input int hold);
      repeat (hold) tick(1'b0, 1'b1);
      repeat (hold) tick(1'b0, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int first;
      RST = 1'b1;
      SW1 = 1'b0;

      // Reset, then idle
      repeat (3) tick(1'b1, 1'b0);
      check("reset_leds", leds, 8'h00);
      repeat (50) tick(1'b0, 1'b0);

      // Press latency: first LED7 edge counted from the sampling edge
      first = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b1);
         if (first == 0 && LED7 === 1'b1) first = i + 1;
      end
      check("press_latency", first, D + 4);
      repeat (20) tick(1'b0, 1'b0);

      // Glitch shorter than the debounce window
      repeat (D - 1) tick(1'b0, 1'b1);
      repeat (20) tick(1'b0, 1'b0);

      // BLINK -> CHASE, watch a full lap and the wrap
      press_release(10);
      repeat (80) tick(1'b0, 1'b0);

      // CHASE -> BREATHE (or OFF), watch a full triangle
      press_release(10);
      repeat (1100) tick(1'b0, 1'b0);

      // One more press: wrap to OFF (four modes) or BLINK (three modes)
      press_release(10);
      repeat (40) tick(1'b0, 1'b0);

      // Reset during CHASE
      repeat (3) tick(1'b1, 1'b0);
      repeat (5) tick(1'b0, 1'b0);
      press_release(8);
      press_release(8);
      repeat (30) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      check("rst_in_chase", leds, 8'h00);
      repeat (20) tick(1'b0, 1'b0);

      // Button held through reset registers one press after release
      repeat (3) tick(1'b1, 1'b1);
      repeat (20) tick(1'b0, 1'b1);
      repeat (20) tick(1'b0, 1'b0);

      // Randomized segments: glitches, clean holds, long holds, random resets
      for (int s = 0; s < 60; s++) begin
         int r;
         int len;
         bit lvl;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            len = $urandom_range(1, 3);
            repeat (len) tick(1'b1, 1'($urandom_range(0, 1)));
         end
         r = $urandom_range(0, 9);
         if (r < 3)      len = $urandom_range(1, D - 1);
         else if (r < 9) len = $urandom_range(D, 3 * D);
         else            len = $urandom_range(300, 1100);
         lvl = 1'($urandom_range(0, 1));
         repeat (len) tick(1'b0, lvl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Drives the Alhambra II LED bank (LED7..LED0) from a single push-button, replacing the fixed free-running blink with four user-selectable display modes: off, blink, chase, breathe. It sits between the board button pin SW1 and the LED pins, running entirely on the 12 MHz board clock. Internally it has a two-flop synchroniser, a debouncer, a mode FSM, a step prescaler and an 8-bit PWM.

## Interface
- DEBOUNCE_CYC, 240000: consecutive cycles of changed input needed to accept a button level (20 ms at 12 MHz).
- STEP_CYC, 1500000: cycles per blink/chase step (125 ms).
- BREATHE_CYC, 23437: cycles per ±1 change of breathe duty.
- CLK  input  1  board clock, 12 MHz.
- RST  input  1  reset; one clock; synchronous, active-high.
- SW1  input  1  push-button, 1 = pressed, asynchronous to CLK.
- LED7..LED0  output  1 each  LED drive, 1 = lit; all registered.

## Operation
- **Synchroniser:** SW1 → s1 → s2, both reset to 0.
- **Debouncer:**
  - Holds `stable` (reset 0) and a counter (reset 0).
  - Each cycle s2 != stable, the counter increments; when it reaches DEBOUNCE_CYC, `stable` flips and the counter clears.
  - Any cycle s2 == stable clears the counter.
  - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- **Press event:** one-cycle pulse when `stable` goes 0→1. Release generates nothing.
- **Mode FSM:**
  - States OFF(0), BLINK(1), CHASE(2), BREATHE(3); reset OFF.
  - A press advances to the next state; BREATHE→OFF wraps.
- **Mode entry:** on every mode change, these restart:
  - step counter to 0
  - blink phase to 1
  - chase position to LED0
  - duty to 0, direction up
- **Step tick:** counter runs 0..STEP_CYC-1 and pulses at wrap. It runs only in BLINK and CHASE.
- **Mode outputs:**
  - OFF: all LEDs 0.
  - BLINK: LED7 = phase, which toggles on each tick; LED6..LED0 = 0.
  - CHASE: exactly one LED lit. Position advances LED0→LED1→…→LED7→LED0 on each tick.
  - BREATHE:
    - PWM counter: 8-bit, free-running.
    - All eight LEDs = (pwm < duty).
    - Every BREATHE_CYC cycles, duty steps by 1 as a triangle: 0→255, then 255→0, repeating.
    - Direction reverses at 255 and at 0; the endpoint value is held for exactly one step.
- **Simultaneous press and tick:** the mode change wins and the tick is discarded.
- **Reset mid-operation:** all state returns to reset values on the next edge. A button held through reset registers one press DEBOUNCE_CYC+4 cycles after RST falls.

## Timing
- All outputs are 0 during reset and on the first cycle after reset.
- Press-to-LED latency, from the edge sampling SW1=1 into s1, with SW1 held:
  - `stable` = 1 after DEBOUNCE_CYC+2 edges
  - mode updates 1 edge later
  - LEDs update 1 edge after that
  - Total: DEBOUNCE_CYC+4 cycles.
- Tick to LED change: 1 cycle.
- Minimum press spacing: a second press requires release and re-press, each held ≥ DEBOUNCE_CYC cycles.
- PWM period: 256 cycles, duty resolution 1/256. Duty 0 means fully off; duty 255 means lit 255 of 256 cycles.

## Configuration
- **LED_BREATHE_EN**
  - Defined: BREATHE mode, PWM counter and duty logic are compiled in. The FSM has four states.
  - Undefined: BREATHE logic is absent and the FSM has three states. CHASE→OFF wraps, and all other behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYC=4, STEP_CYC=8, BREATHE_CYC=1.

- **Reset:** RST high 3 cycles, SW1=0 → all LEDs 0, mode OFF for 50 cycles.
- **Press latency:** SW1 high at cycle 10, held 20 cycles → LED7=1 first at cycle 18; LED7 then toggles every 8 cycles.
- **Glitch rejection:** SW1 high for 3 cycles, then low → no mode change, LEDs stay 0.
- **Chase wrap:** two clean presses, observe 80 cycles → one-hot LED0..LED7, each held 8 cycles, LED0 again after LED7.
- **Breathe (macro defined):** three presses → duty reaches 255 after 255 steps, then descends. Count of lit cycles per 256-cycle window equals the current duty.
- **Wrap and reset:**
  - Four presses → OFF.
  - With LED_BREATHE_EN undefined, three presses → OFF.
  - RST during CHASE → all LEDs 0 next cycle and mode OFF.
